// File: rtl/sd_mod_sequencer.sv
// ---------------------------------------------------------------------------
// sd_mod_sequencer
//
// Feeds the sigma-delta modulator (sd_filter_top) from a PCM sample stream.
// Incoming samples are buffered in a small FIFO. The modulator is started
// with clk_enable held low for a warm-up period. Each sample is then held on
// the modulator input for exactly OSR clocks. Underflow is handled by
// repeating the last sample or driving zero. On stop, the current sample is
// allowed to finish, and zeros are fed for a drain period before returning
// to idle.
//
// Ports
//   clk             in   1   system / modulator clock
//   aresetn         in   1   asynchronous active-low reset
//   run             in   1   level: 1 = start/continue, 0 = stop
//   s_tdata         in   W   signed PCM sample
//   s_tvalid        in   1   s_tdata valid
//   s_tready        out  1   sample accepted when s_tvalid & s_tready
//   mod_clk_enable  out  1   modulator clk_enable
//   mod_input       out  W   modulator input_rsvd (registered)
//   sample_strobe   out  1   one-cycle pulse when mod_input takes a new value
//   underflow       out  1   sticky: a RUN slot found the FIFO empty
//   underflow_clr   in   1   clears underflow (a coincident set wins)
//   state           out  2   0 IDLE, 1 WARM, 2 RUN, 3 DRAIN
// ---------------------------------------------------------------------------
module sd_mod_sequencer #(
    parameter int OSR        = 256,
    parameter int W          = 16,
    parameter int WARMUP     = 32,
    parameter int DEPTH      = 4,
    parameter int DRAIN_CLKS = 512,
    parameter int UF_ZERO    = 0
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         run,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic         mod_clk_enable,
    output logic [W-1:0] mod_input,
    output logic         sample_strobe,
    output logic         underflow,
    input  logic         underflow_clr,
    output logic [1:0]   state
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int PW   = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int TMAX = (WARMUP > DRAIN_CLKS) ? WARMUP : DRAIN_CLKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0]   PHASE_LAST = PW'(OSR - 1);
    localparam logic [TW-1:0]   WARM_LAST  = TW'(WARMUP - 1);
    localparam logic [TW-1:0]   DRAIN_LAST = TW'(DRAIN_CLKS - 1);
    localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WARM  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            clk_en_q, clk_en_d;
    logic [W-1:0]    mod_input_q, mod_input_d;
    logic            strobe_q, strobe_d;
    logic            underflow_q, underflow_d;

    logic [W-1:0]    mem [DEPTH];

    logic            push;
    logic            pop;
    logic            slot;
    logic            flush;
    logic            fifo_empty;

    // Handshake and slot decode. s_tready is a registered flag derived from
    // the registered count, so a pop that frees a full FIFO only opens the
    // input on the following cycle. A slot is the phase-0 cycle of RUN.
    always_comb begin
        fifo_empty = (count_q == '0);
        push       = s_tvalid && ready_q;
        slot       = (state_q == S_RUN) && (phase_q == '0);
        pop        = slot && !fifo_empty;
    end

    // Sequencer next-state logic. Timers are cleared on entry to WARM and to
    // DRAIN and count up to the last clock of that period. In RUN the phase
    // counter wraps every OSR clocks. The stop request is only looked at on
    // the last phase, so a sample in progress always completes.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tmr_d       = tmr_q;
        mod_input_d = mod_input_q;
        strobe_d    = 1'b0;
        underflow_d = underflow_q && !underflow_clr;
        flush       = 1'b0;

        case (state_q)
            S_IDLE: begin
                mod_input_d = '0;
                phase_d     = '0;
                if (run) begin
                    state_d = S_WARM;
                    tmr_d   = '0;
                end
            end

            S_WARM: begin
                mod_input_d = '0;
                if (!run) begin
                    state_d = S_IDLE;
                end else if (tmr_q == WARM_LAST) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            S_RUN: begin
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);

                // A slot always produces a strobe. On an empty FIFO the
                // slot is flagged as underflow, and the held value is
                // repeated or zero is driven.
                if (slot) begin
                    strobe_d = 1'b1;
                    if (!fifo_empty) begin
                        mod_input_d = mem[rd_ptr_q];
                    end else begin
                        underflow_d = 1'b1;
                        if (UF_ZERO != 0) begin
                            mod_input_d = '0;
                        end
                    end
                end

                if ((phase_q == PHASE_LAST) && !run) begin
                    state_d     = S_DRAIN;
                    tmr_d       = '0;
                    phase_d     = '0;
                    mod_input_d = '0;
                    flush       = 1'b1;
                end
            end

            S_DRAIN: begin
                mod_input_d = '0;
                if (tmr_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        clk_en_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // FIFO pointer/count update. Entering DRAIN discards everything buffered,
    // including a sample pushed on that same edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end

        ready_d = (count_d != FULL_CNT) && (state_d != S_DRAIN);
    end

    // All sequencer and FIFO control state. Reset returns everything to IDLE
    // with every output low.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            tmr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            clk_en_q    <= 1'b0;
            mod_input_q <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tmr_q       <= tmr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            clk_en_q    <= clk_en_d;
            mod_input_q <= mod_input_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
        end
    end

    // Sample storage. It has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= s_tdata;
        end
    end

    assign s_tready       = ready_q;
    assign mod_clk_enable = clk_en_q;
    assign mod_input      = mod_input_q;
    assign sample_strobe  = strobe_q;
    assign underflow      = underflow_q;
    assign state          = state_q;

endmodule

// File: tb/tb_sd_mod_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sd_mod_sequencer
//
// Directed bench for sd_mod_sequencer. The main instance uses the default
// parameters (OSR 256, WARMUP 32, DRAIN 512, repeat-on-underflow). A second
// instance uses short periods and zero-on-underflow. It covers the
// zero-underflow case and a long gap-free noise stream.
// ---------------------------------------------------------------------------
module tb_sd_mod_sequencer;

    localparam int N      = 4096;
    localparam int OSR_Z  = 8;

    logic        clk = 1'b0;

    logic        rstn   = 1'b0;
    logic        run    = 1'b0;
    logic [15:0] sData  = '0;
    logic        sValid = 1'b0;
    logic        ufClr  = 1'b0;
    logic        sReady;
    logic        cen;
    logic [15:0] modIn;
    logic        strobe;
    logic        uf;
    logic [1:0]  st;

    logic        rstnZ   = 1'b0;
    logic        runZ    = 1'b0;
    logic [15:0] dataZ   = '0;
    logic        validZ  = 1'b0;
    logic        clrZ    = 1'b0;
    logic        readyZ;
    logic        cenZ;
    logic [15:0] modZ;
    logic        strobeZ;
    logic        ufZ;
    logic [1:0]  stZ;

    int          nChecks;
    int          nPass;
    int          nFail;
    logic [15:0] noise [N];

    // Free-running 10 ns clock shared by both instances.
    always #5 clk = ~clk;

    sd_mod_sequencer dut (
        .clk            (clk),
        .aresetn        (rstn),
        .run            (run),
        .s_tdata        (sData),
        .s_tvalid       (sValid),
        .s_tready       (sReady),
        .mod_clk_enable (cen),
        .mod_input      (modIn),
        .sample_strobe  (strobe),
        .underflow      (uf),
        .underflow_clr  (ufClr),
        .state          (st)
    );

    sd_mod_sequencer #(
        .OSR        (OSR_Z),
        .W          (16),
        .WARMUP     (4),
        .DEPTH      (4),
        .DRAIN_CLKS (16),
        .UF_ZERO    (1)
    ) dutz (
        .clk            (clk),
        .aresetn        (rstnZ),
        .run            (runZ),
        .s_tdata        (dataZ),
        .s_tvalid       (validZ),
        .s_tready       (readyZ),
        .mod_clk_enable (cenZ),
        .mod_input      (modZ),
        .sample_strobe  (strobeZ),
        .underflow      (ufZ),
        .underflow_clr  (clrZ),
        .state          (stZ)
    );

    // Advance to the n-th following falling edge, where outputs are sampled
    // and new inputs are driven.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the main instance inputs.
    task automatic applyStimulus(input logic runV, input logic [15:0] dataV,
                                 input logic validV, input logic clrV);
        run    = runV;
        sData  = dataV;
        sValid = validV;
        ufClr  = clrV;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, start-up timing, underflow/clear, backpressure,
    // stop/drain, mid-run reset, then the zero-underflow and stream checks on
    // the short instance.
    initial begin
        int k;
        int hold;
        int d;
        logic bad;
        int idx;
        int outIdx;
        int holdCnt;
        int cyc;
        logic pushedLast;

        nChecks = 0;
        nPass   = 0;
        nFail   = 0;
        for (int i = 0; i < N; i++) noise[i] = 16'($urandom);

        tick(2);
        checkOutput("rst_state",  32'(st),     32'd0);
        checkOutput("rst_ready",  32'(sReady), 32'd0);
        checkOutput("rst_cen",    32'(cen),    32'd0);
        checkOutput("rst_mod",    32'(modIn),  32'd0);
        checkOutput("rst_strobe", 32'(strobe), 32'd0);
        checkOutput("rst_uf",     32'(uf),     32'd0);

        rstn = 1'b1;
        tick(1);
        checkOutput("idle_ready", 32'(sReady), 32'd1);
        checkOutput("idle_state", 32'(st),     32'd0);

        // Pre-load two samples while idle.
        applyStimulus(1'b0, 16'h0100, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 16'h0200, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick(3);
        checkOutput("idle_hold", 32'(st),  32'd0);
        checkOutput("idle_cen",  32'(cen), 32'd0);

        // Start: clk_enable rises 32 clocks after WARM entry.
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        tick(1);
        checkOutput("warm_state", 32'(st),  32'd1);
        checkOutput("warm_cen",   32'(cen), 32'd0);
        k = 0;
        while (cen !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        checkOutput("warm_len",  32'(k),     32'd32);
        checkOutput("run_state", 32'(st),    32'd2);
        checkOutput("run_mod0",  32'(modIn), 32'd0);

        tick(1);
        checkOutput("first_mod",    32'(modIn),  32'h0100);
        checkOutput("first_strobe", 32'(strobe), 32'd1);

        hold = 0;
        while (modIn === 16'h0100 && hold < 400) begin
            hold++;
            tick(1);
        end
        checkOutput("first_hold",    32'(hold),   32'd256);
        checkOutput("second_mod",    32'(modIn),  32'h0200);
        checkOutput("second_strobe", 32'(strobe), 32'd1);
        checkOutput("second_uf",     32'(uf),     32'd0);

        // Empty FIFO at the next slot: repeat the last sample.
        tick(256);
        checkOutput("uf_repeat_mod", 32'(modIn),  32'h0200);
        checkOutput("uf_set",        32'(uf),     32'd1);
        checkOutput("uf_strobe",     32'(strobe), 32'd1);

        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        checkOutput("uf_clear", 32'(uf), 32'd0);

        // Clear coincident with an underflowing slot: set wins.
        tick(254);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        checkOutput("uf_set_wins",    32'(uf),     32'd1);
        checkOutput("uf_set_strobe",  32'(strobe), 32'd1);
        checkOutput("uf_set_mod",     32'(modIn),  32'h0200);

        // Backpressure: fill the FIFO, then hold a fifth sample on the input.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'(16'h0A01 + i), 1'b1, 1'b0);
            tick(1);
        end
        applyStimulus(1'b1, 16'h0A05, 1'b1, 1'b0);
        checkOutput("full_ready", 32'(sReady), 32'd0);
        tick(252);
        checkOutput("pop_full_ready",  32'(sReady), 32'd1);
        checkOutput("pop_full_mod",    32'(modIn),  32'h0A01);
        checkOutput("pop_full_strobe", 32'(strobe), 32'd1);
        tick(1);
        checkOutput("refill_ready", 32'(sReady), 32'd0);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);

        tick(255);
        checkOutput("next_mod",    32'(modIn),  32'h0A02);
        checkOutput("next_strobe", 32'(strobe), 32'd1);

        // Stop at phase 10: the sample is held through phase 255.
        tick(9);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick(245);
        checkOutput("stop_last_state", 32'(st),    32'd2);
        checkOutput("stop_last_mod",   32'(modIn), 32'h0A02);
        checkOutput("stop_last_cen",   32'(cen),   32'd1);
        tick(1);
        checkOutput("drain_state", 32'(st),     32'd3);
        checkOutput("drain_mod",   32'(modIn),  32'd0);
        checkOutput("drain_cen",   32'(cen),    32'd1);
        checkOutput("drain_ready", 32'(sReady), 32'd0);

        d   = 0;
        bad = 1'b0;
        while (st === 2'd3 && d < 1000) begin
            if (modIn !== 16'h0000 || cen !== 1'b1 || sReady !== 1'b0) bad = 1'b1;
            d++;
            tick(1);
        end
        checkOutput("drain_len",     32'(d),     32'd512);
        checkOutput("drain_outputs", 32'(bad),   32'd0);
        checkOutput("end_state",     32'(st),    32'd0);
        checkOutput("end_cen",       32'(cen),   32'd0);
        checkOutput("end_mod",       32'(modIn), 32'd0);

        // A flushed FIFO still has room after three new samples.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'(16'h0B01 + i), 1'b1, 1'b0);
            tick(1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("flush_ready", 32'(sReady), 32'd1);
        checkOutput("uf_sticky",   32'(uf),     32'd1);

        // Restart, then reset asynchronously in the middle of RUN.
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        tick(1);
        checkOutput("rerun_state", 32'(st), 32'd1);
        tick(33);
        checkOutput("rerun_mod",   32'(modIn), 32'h0B01);
        checkOutput("rerun_state2", 32'(st),   32'd2);
        tick(20);
        rstn = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("arst_state",  32'(st),     32'd0);
        checkOutput("arst_cen",    32'(cen),    32'd0);
        checkOutput("arst_mod",    32'(modIn),  32'd0);
        checkOutput("arst_strobe", 32'(strobe), 32'd0);
        checkOutput("arst_uf",     32'(uf),     32'd0);
        checkOutput("arst_ready",  32'(sReady), 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(5);
        checkOutput("post_rst_state", 32'(st),     32'd0);
        checkOutput("post_rst_cen",   32'(cen),    32'd0);
        checkOutput("post_rst_ready", 32'(sReady), 32'd1);

        // Zero-on-underflow instance: one sample, then an empty slot.
        rstnZ = 1'b1;
        tick(1);
        dataZ  = 16'h1234;
        validZ = 1'b1;
        tick(1);
        validZ = 1'b0;
        runZ   = 1'b1;
        tick(1);
        tick(5);
        checkOutput("z_first_mod", 32'(modZ),    32'h1234);
        checkOutput("z_first_uf",  32'(ufZ),     32'd0);
        tick(8);
        checkOutput("z_uf_mod",    32'(modZ),    32'h0000);
        checkOutput("z_uf_set",    32'(ufZ),     32'd1);
        checkOutput("z_uf_strobe", 32'(strobeZ), 32'd1);

        // Gap-free stream of noise samples through the short instance.
        rstnZ = 1'b0;
        runZ  = 1'b0;
        tick(1);
        rstnZ = 1'b1;
        tick(1);
        idx        = 0;
        outIdx     = 0;
        holdCnt    = 0;
        cyc        = 0;
        pushedLast = 1'b0;
        runZ       = 1'b1;
        while (outIdx < N && cyc < N * OSR_Z + 200) begin
            if (pushedLast) idx++;
            if (strobeZ === 1'b1) begin
                checkOutput("stream_data", 32'(modZ), 32'(noise[outIdx]));
                if (outIdx > 0) checkOutput("stream_hold", 32'(holdCnt), 32'(OSR_Z));
                holdCnt = 0;
                outIdx++;
            end
            holdCnt++;
            validZ     = (idx < N);
            dataZ      = (idx < N) ? noise[idx] : 16'h0000;
            pushedLast = validZ && (readyZ === 1'b1);
            tick(1);
            cyc++;
        end
        checkOutput("stream_count", 32'(outIdx), 32'(N));
        checkOutput("stream_uf",    32'(ufZ),    32'd0);
        validZ = 1'b0;
        runZ   = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
